// File: rtl/l1_req_arbiter.sv
// Two-requester arbiter for a single L1 request port: demand-first with a prefetch
// starvation guard, grant locking until acceptance, and in-order response steering.
module l1_req_arbiter #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_data_i,
    input  logic                  d_rw_i,
    input  logic                  d_valid_i,
    output logic                  d_ready_o,
    input  logic [ADDR_WIDTH-1:0] p_addr_i,
    input  logic [DATA_WIDTH-1:0] p_data_i,
    input  logic                  p_rw_i,
    input  logic                  p_valid_i,
    output logic                  p_ready_o,
    output logic [ADDR_WIDTH-1:0] l1_addr_o,
    output logic [DATA_WIDTH-1:0] l1_data_o,
    output logic                  l1_rw_o,
    output logic                  l1_valid_o,
    input  logic                  l1_ready_i,
    input  logic [DATA_WIDTH-1:0] l1_rsp_data_i,
    input  logic                  l1_rsp_valid_i,
    output logic [DATA_WIDTH-1:0] d_rsp_data_o,
    output logic                  d_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] p_rsp_data_o,
    output logic                  p_rsp_valid_o,
    output logic                  p_busy_o,
    output logic                  rsp_err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

    typedef enum logic {SRC_D = 1'b0, SRC_P = 1'b1} src_e;

    logic             lock_q, lock_d;
    src_e             lock_src_q, lock_src_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, pf_cnt_q, pf_cnt_d;
    logic             rsp_err_q, rsp_err_d;

    logic [MAX_OUTSTANDING-1:0] id_vec;
    logic  rd_room, d_elig, p_elig, gnt_valid, accept, push, pop, head_is_p;
    src_e  gnt_src;

    assign rd_room = (cnt_q < CNT_MAX);
    assign d_elig  = d_valid_i & (d_rw_i | rd_room);
    assign p_elig  = p_valid_i & (p_rw_i | rd_room);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_src   = SRC_D;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt_src   = lock_src_q;
        end else if (p_elig && starve_q == ST_MAX) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_P;
        end else if (d_elig) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_D;
        end else if (p_elig) begin
            gnt_valid = 1'b1;
            gnt_src   = SRC_P;
        end
    end

    assign l1_valid_o = gnt_valid;
    assign l1_addr_o  = (gnt_src == SRC_P) ? p_addr_i : d_addr_i;
    assign l1_data_o  = (gnt_src == SRC_P) ? p_data_i : d_data_i;
    assign l1_rw_o    = (gnt_src == SRC_P) ? p_rw_i   : d_rw_i;
    assign d_ready_o  = gnt_valid & (gnt_src == SRC_D) & l1_ready_i;
    assign p_ready_o  = gnt_valid & (gnt_src == SRC_P) & l1_ready_i;

    assign accept    = gnt_valid & l1_ready_i;
    assign push      = accept & ~l1_rw_o;
    assign pop       = l1_rsp_valid_i & (cnt_q != '0);
    assign head_is_p = id_vec[rd_ptr_q];

    assign d_rsp_data_o  = l1_rsp_data_i;
    assign p_rsp_data_o  = l1_rsp_data_i;
    assign d_rsp_valid_o = pop & ~head_is_p;
    assign p_rsp_valid_o = pop & head_is_p;
    assign p_busy_o      = p_valid_i | (pf_cnt_q != '0);
    assign rsp_err_o     = rsp_err_q;

    // Source-ID storage; only ever read while the entry is occupied, so no reset needed.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_id
            logic id_q;
            always_ff @(posedge clk) begin
                if (push && wr_ptr_q == PTR_W'(gi)) begin
                    id_q <= gnt_src;
                end
            end
            assign id_vec[gi] = id_q;
        end
    endgenerate

    always_comb begin
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        starve_d   = starve_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        pf_cnt_d   = pf_cnt_q;
        rsp_err_d  = rsp_err_q | (l1_rsp_valid_i & (cnt_q == '0));

        if (gnt_valid && !l1_ready_i) begin
            lock_d     = 1'b1;
            lock_src_d = gnt_src;
        end else if (accept) begin
            lock_d = 1'b0;
        end

        if (accept && gnt_src == SRC_P) begin
            starve_d = '0;
        end else if (accept && p_valid_i && starve_q != ST_MAX) begin
            starve_d = starve_q + ST_W'(1);
        end

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        case ({push && gnt_src == SRC_P, pop && head_is_p})
            2'b10:   pf_cnt_d = pf_cnt_q + CNT_W'(1);
            2'b01:   pf_cnt_d = pf_cnt_q - CNT_W'(1);
            default: pf_cnt_d = pf_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_D;
            starve_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            pf_cnt_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            starve_q   <= starve_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            pf_cnt_q   <= pf_cnt_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_l1_req_arbiter.sv
// Self-checking bench for l1_req_arbiter: vector table, directed multi-cycle
// sequences, then constrained-random traffic against a queue-based reference model.
module tb_l1_req_arbiter;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MO = 4;
    localparam int SL = 8;

    logic          clk, rst;
    logic [AW-1:0] d_addr, p_addr, l1_addr;
    logic [DW-1:0] d_data, p_data, l1_data, l1_rsp_data, d_rsp_data, p_rsp_data;
    logic          d_rw, d_valid, d_ready, p_rw, p_valid, p_ready;
    logic          l1_rw, l1_valid, l1_ready, l1_rsp_valid;
    logic          d_rsp_valid, p_rsp_valid, p_busy, rsp_err;

    l1_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .d_addr_i(d_addr), .d_data_i(d_data), .d_rw_i(d_rw), .d_valid_i(d_valid), .d_ready_o(d_ready),
        .p_addr_i(p_addr), .p_data_i(p_data), .p_rw_i(p_rw), .p_valid_i(p_valid), .p_ready_o(p_ready),
        .l1_addr_o(l1_addr), .l1_data_o(l1_data), .l1_rw_o(l1_rw), .l1_valid_o(l1_valid),
        .l1_ready_i(l1_ready), .l1_rsp_data_i(l1_rsp_data), .l1_rsp_valid_i(l1_rsp_valid),
        .d_rsp_data_o(d_rsp_data), .d_rsp_valid_o(d_rsp_valid),
        .p_rsp_data_o(p_rsp_data), .p_rsp_valid_o(p_rsp_valid),
        .p_busy_o(p_busy), .rsp_err_o(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 2 ns later.
    task automatic apply(input logic dv, input logic drw, input logic pv, input logic prw,
                         input logic rdy, input logic rv, input logic [DW-1:0] rdata);
        @(negedge clk);
        d_valid = dv; d_rw = drw; p_valid = pv; p_rw = prw;
        l1_ready = rdy; l1_rsp_valid = rv; l1_rsp_data = rdata;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        d_valid = 1'b0; p_valid = 1'b0; l1_ready = 1'b0; l1_rsp_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic dv, drw, pv, prw, rdy, rv;
        logic [DW-1:0] rdata;
        logic lv, src, dr, pr, drv, prv, busy, err;
    } vec_t;
    vec_t tbl[20];

    // Reference model state
    bit m_lock;
    int m_lock_who;
    int m_starve;
    int m_q[$];
    bit m_err;

    initial begin
        rst = 1'b1;
        d_addr = 16'h1111; d_data = 32'hDDDD_0001; d_rw = 1'b0; d_valid = 1'b0;
        p_addr = 16'h2222; p_data = 32'hEEEE_0002; p_rw = 1'b0; p_valid = 1'b0;
        l1_ready = 1'b0; l1_rsp_valid = 1'b0; l1_rsp_data = '0;

        // Reset state, checked while reset is held
        repeat (2) @(negedge clk);
        #2;
        chk("rst.l1_valid", 64'(l1_valid), 64'(0));
        chk("rst.d_ready", 64'(d_ready), 64'(0));
        chk("rst.p_ready", 64'(p_ready), 64'(0));
        chk("rst.d_rsp_valid", 64'(d_rsp_valid), 64'(0));
        chk("rst.p_rsp_valid", 64'(p_rsp_valid), 64'(0));
        chk("rst.p_busy", 64'(p_busy), 64'(0));
        chk("rst.rsp_err", 64'(rsp_err), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Fields: dv drw pv prw rdy rv | rdata | lv src dr pr drv prv busy err
        tbl[0]  = {6'b100010, 32'h0,  8'b10100000};  // demand read
        tbl[1]  = {6'b001010, 32'h0,  8'b11010010};  // prefetch read
        tbl[2]  = {6'b100010, 32'h0,  8'b10100010};  // demand read
        tbl[3]  = {6'b000001, 32'hA,  8'b00001010};  // rsp -> demand
        tbl[4]  = {6'b000001, 32'hB,  8'b00000110};  // rsp -> prefetch
        tbl[5]  = {6'b000001, 32'hC,  8'b00001000};  // rsp -> demand, busy drops
        tbl[6]  = {6'b100010, 32'h0,  8'b10100000};
        tbl[7]  = {6'b100010, 32'h0,  8'b10100000};
        tbl[8]  = {6'b100010, 32'h0,  8'b10100000};
        tbl[9]  = {6'b100010, 32'h0,  8'b10100000};  // fourth read: FIFO full
        tbl[10] = {6'b100010, 32'h0,  8'b00000000};  // read blocked
        tbl[11] = {6'b110010, 32'h0,  8'b10100000};  // write still passes
        tbl[12] = {6'b100011, 32'h55, 8'b00001000};  // pop same cycle: read still blocked
        tbl[13] = {6'b100010, 32'h0,  8'b10100000};  // read accepted after the pop
        tbl[14] = {6'b000001, 32'h60, 8'b00001000};
        tbl[15] = {6'b000001, 32'h61, 8'b00001000};
        tbl[16] = {6'b000001, 32'h62, 8'b00001000};
        tbl[17] = {6'b000001, 32'h63, 8'b00001000};
        tbl[18] = {6'b000001, 32'h77, 8'b00000000};  // response with FIFO empty
        tbl[19] = {6'b000000, 32'h0,  8'b00000001};  // error is sticky

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].dv, tbl[i].drw, tbl[i].pv, tbl[i].prw, tbl[i].rdy, tbl[i].rv, tbl[i].rdata);
            chk($sformatf("tbl%0d.l1_valid", i), 64'(l1_valid), 64'(tbl[i].lv));
            if (tbl[i].lv) begin
                chk($sformatf("tbl%0d.l1_addr", i), 64'(l1_addr), 64'(tbl[i].src ? p_addr : d_addr));
                chk($sformatf("tbl%0d.l1_rw", i), 64'(l1_rw), 64'(tbl[i].src ? tbl[i].prw : tbl[i].drw));
            end
            chk($sformatf("tbl%0d.d_ready", i), 64'(d_ready), 64'(tbl[i].dr));
            chk($sformatf("tbl%0d.p_ready", i), 64'(p_ready), 64'(tbl[i].pr));
            chk($sformatf("tbl%0d.d_rsp_valid", i), 64'(d_rsp_valid), 64'(tbl[i].drv));
            chk($sformatf("tbl%0d.p_rsp_valid", i), 64'(p_rsp_valid), 64'(tbl[i].prv));
            if (tbl[i].rv) begin
                chk($sformatf("tbl%0d.d_rsp_data", i), 64'(d_rsp_data), 64'(tbl[i].rdata));
                chk($sformatf("tbl%0d.p_rsp_data", i), 64'(p_rsp_data), 64'(tbl[i].rdata));
            end
            chk($sformatf("tbl%0d.p_busy", i), 64'(p_busy), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d.rsp_err", i), 64'(rsp_err), 64'(tbl[i].err));
        end

        // Priority / starvation: 8 demand wins, then prefetch, then demand again
        do_reset();
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, k > 0, DW'(k));
            chk($sformatf("starve%0d.d_ready", k), 64'(d_ready), 64'(k != 8));
            chk($sformatf("starve%0d.p_ready", k), 64'(p_ready), 64'(k == 8));
            chk($sformatf("starve%0d.l1_addr", k), 64'(l1_addr), 64'((k == 8) ? p_addr : d_addr));
            chk($sformatf("starve%0d.d_rsp_valid", k), 64'(d_rsp_valid), 64'(k > 0 && k != 9));
            chk($sformatf("starve%0d.p_rsp_valid", k), 64'(p_rsp_valid), 64'(k == 9));
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        chk("starve.drain.d_rsp_valid", 64'(d_rsp_valid), 64'(1));

        // Lock: prefetch stalled 3 cycles, demand arrives in the second stall cycle
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("lock1.l1_addr", 64'(l1_addr), 64'(p_addr));
        chk("lock1.p_ready", 64'(p_ready), 64'(0));
        for (int c = 2; c <= 3; c++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            chk($sformatf("lock%0d.l1_addr", c), 64'(l1_addr), 64'(p_addr));
            chk($sformatf("lock%0d.d_ready", c), 64'(d_ready), 64'(0));
            chk($sformatf("lock%0d.p_ready", c), 64'(p_ready), 64'(0));
        end
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("lock4.l1_addr", 64'(l1_addr), 64'(p_addr));
        chk("lock4.p_ready", 64'(p_ready), 64'(1));
        chk("lock4.d_ready", 64'(d_ready), 64'(0));
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("lock5.l1_addr", 64'(l1_addr), 64'(d_addr));
        chk("lock5.d_ready", 64'(d_ready), 64'(1));
        chk("lock5.p_busy", 64'(p_busy), 64'(1));
        // Demand read stalls and locks with two reads in flight
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("lock6.l1_valid", 64'(l1_valid), 64'(1));

        // Asynchronous reset in the middle of the lock
        @(negedge clk);
        d_valid = 1'b0; p_valid = 1'b0; l1_ready = 1'b0; l1_rsp_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("arst.l1_valid", 64'(l1_valid), 64'(0));
        chk("arst.d_ready", 64'(d_ready), 64'(0));
        chk("arst.p_ready", 64'(p_ready), 64'(0));
        chk("arst.p_busy", 64'(p_busy), 64'(0));
        chk("arst.rsp_err", 64'(rsp_err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        // Lock gone: prefetch wins; FIFO empty: the response is not routed
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5A);
        chk("post.l1_addr", 64'(l1_addr), 64'(p_addr));
        chk("post.p_ready", 64'(p_ready), 64'(1));
        chk("post.d_rsp_valid", 64'(d_rsp_valid), 64'(0));
        chk("post.p_rsp_valid", 64'(p_rsp_valid), 64'(0));
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("post.rsp_err", 64'(rsp_err), 64'(1));

        // Randomised traffic against the reference model
        do_reset();
        m_lock = 0; m_lock_who = 0; m_starve = 0; m_q.delete(); m_err = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit room, de, pe, e_lv, e_dr, e_pr, e_drv, e_prv, e_busy;
            int who, npf;
            @(negedge clk);
            if (!d_valid) begin
                d_valid = ($urandom % 5) < 3;
                d_addr = AW'($urandom); d_data = DW'($urandom); d_rw = ($urandom % 4) == 0;
            end
            if (!p_valid) begin
                p_valid = ($urandom % 5) < 2;
                p_addr = AW'($urandom); p_data = DW'($urandom); p_rw = ($urandom % 4) == 0;
            end
            l1_ready = ($urandom % 4) != 0;
            l1_rsp_valid = (m_q.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 64) == 0);
            l1_rsp_data = DW'($urandom);
            #2;

            room = m_q.size() < MO;
            de = d_valid && (d_rw || room);
            pe = p_valid && (p_rw || room);
            if (m_lock) who = m_lock_who;
            else if (pe && m_starve == SL) who = 1;
            else if (de) who = 0;
            else if (pe) who = 1;
            else who = -1;
            e_lv = who >= 0;
            e_dr = (who == 0) && l1_ready;
            e_pr = (who == 1) && l1_ready;
            e_drv = l1_rsp_valid && m_q.size() > 0 && m_q[0] == 0;
            e_prv = l1_rsp_valid && m_q.size() > 0 && m_q[0] == 1;
            npf = 0;
            foreach (m_q[j]) if (m_q[j] == 1) npf++;
            e_busy = p_valid || npf > 0;

            chk("rnd.l1_valid", 64'(l1_valid), 64'(e_lv));
            if (e_lv) begin
                chk("rnd.l1_addr", 64'(l1_addr), 64'((who == 1) ? p_addr : d_addr));
                chk("rnd.l1_data", 64'(l1_data), 64'((who == 1) ? p_data : d_data));
                chk("rnd.l1_rw", 64'(l1_rw), 64'((who == 1) ? p_rw : d_rw));
            end
            chk("rnd.d_ready", 64'(d_ready), 64'(e_dr));
            chk("rnd.p_ready", 64'(p_ready), 64'(e_pr));
            chk("rnd.d_rsp_valid", 64'(d_rsp_valid), 64'(e_drv));
            chk("rnd.p_rsp_valid", 64'(p_rsp_valid), 64'(e_prv));
            if (l1_rsp_valid) chk("rnd.d_rsp_data", 64'(d_rsp_data), 64'(l1_rsp_data));
            chk("rnd.p_busy", 64'(p_busy), 64'(e_busy));
            chk("rnd.rsp_err", 64'(rsp_err), 64'(m_err));

            // Advance the model to the state after the coming rising edge
            if (who >= 0 && !l1_ready) begin
                m_lock = 1; m_lock_who = who;
            end else if (who >= 0) begin
                m_lock = 0;
            end
            if (who == 1 && l1_ready) m_starve = 0;
            else if (who == 0 && l1_ready && p_valid && m_starve < SL) m_starve++;
            if (l1_rsp_valid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1;
            end
            if (who >= 0 && l1_ready && !((who == 1) ? p_rw : d_rw)) m_q.push_back(who);

            @(posedge clk);
            #1;
            if (e_dr) d_valid = 1'b0;
            if (e_pr) p_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/l1_req_arbiter.md
# l1_req_arbiter

Shares one L1 cache request port between two requesters: SIMD-core demand traffic (port `d_`) and prefetch-core traffic (port `p_`).
- Demand has priority; a starvation counter guarantees prefetch forward progress.
- Granted requests stay locked until L1 accepts them.
- An in-order ID FIFO routes each read response back to the requester that issued it.
- Drives the prefetch-core `p_busy` status.

## Interface
- DATA_WIDTH, 512, request/response data width
- ADDR_WIDTH, 64, request address width
- MAX_OUTSTANDING, 4, max in-flight reads (ID FIFO depth, ≥2)
- STARVE_LIMIT, 8, demand wins after which prefetch is forced (≥1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- d_addr/d_data/d_rw/d_valid  in  ADDR_WIDTH/DATA_WIDTH/1/1  demand request (rw=1 write, rw=0 read)
- d_ready  out  1  demand request accepted
- p_addr/p_data/p_rw/p_valid  in  ADDR_WIDTH/DATA_WIDTH/1/1  prefetch request
- p_ready  out  1  prefetch request accepted
- l1_addr/l1_data/l1_rw/l1_valid  out  ADDR_WIDTH/DATA_WIDTH/1/1  request to L1
- l1_ready  in  1  L1 accepts request
- l1_rsp_data/l1_rsp_valid  in  DATA_WIDTH/1  L1 read response, one per read, in order
- d_rsp_data/d_rsp_valid  out  DATA_WIDTH/1  demand response
- p_rsp_data/p_rsp_valid  out  DATA_WIDTH/1  prefetch response
- p_busy  out  1  prefetch request pending or prefetch read in flight
- rsp_err  out  1  sticky: response arrived with no read outstanding

## Operation
- **Eligibility.** A requester is eligible when its valid=1 and either it is a write, or `cnt < MAX_OUTSTANDING`. `cnt` is the number of reads in flight.
- **Grant select** (combinational, in priority order):
  - If `lock` is set, grant `lock_src`.
  - Else, if prefetch is eligible and `starve == STARVE_LIMIT`, grant prefetch.
  - Else, if demand is eligible, grant demand.
  - Else, if prefetch is eligible, grant prefetch.
  - Else, no grant.
- **L1 request.** `l1_valid` = a grant exists; `l1_addr/data/rw` mux from the granted port. Only the granted port's ready = `l1_ready`; the other port's ready = 0.
- **Lock.**
  - Set, with `lock_src` = current grant, when `l1_valid & !l1_ready`.
  - Cleared on acceptance (`l1_valid & l1_ready`).
  - Requesters must hold valid and payload stable until ready.
- **Starvation counter** (`starve`, `$clog2(STARVE_LIMIT+1)` bits):
  - +1, saturating at STARVE_LIMIT, on each accepted demand request while `p_valid=1`.
  - Cleared to 0 on each accepted prefetch request.
  - Otherwise holds.
- **ID FIFO.**
  - Push the source ID (0 = demand, 1 = prefetch) on each accepted read. Writes are never pushed and get no response.
  - Pop on `l1_rsp_valid` when non-empty.
  - Head ID steers the response: `d_rsp_valid = l1_rsp_valid & head==0`, `p_rsp_valid = l1_rsp_valid & head==1`. Both `rsp_data` outputs = `l1_rsp_data`.
- **Empty-FIFO response.** `l1_rsp_valid` with the FIFO empty: both rsp_valid = 0, `rsp_err` set, and it stays set until reset.
- **Simultaneous push and pop.** Both happen; `cnt` unchanged; pointers wrap modulo MAX_OUTSTANDING.
- **Full FIFO.** At `cnt == MAX_OUTSTANDING`, reads are ineligible even if a pop occurs the same cycle; writes still proceed. A locked read is never blocked: the push happens only at acceptance, so `cnt` cannot reach full while the lock is held.
- **Prefetch busy.** `pf_cnt` counts prefetch IDs in the FIFO. `p_busy = p_valid | (pf_cnt != 0)`.

## Timing
- Request path is combinational, zero cycles: valid/payload → `l1_*`, and `l1_ready` → `d_ready`/`p_ready`.
- Response path is combinational, zero cycles: `l1_rsp_*` → `d_rsp_*`/`p_rsp_*`.
- State updates on the rising clk edge: lock, `lock_src`, `starve`, FIFO, `cnt`, `pf_cnt`, `rsp_err`.
- `p_busy` is combinational from `p_valid` and registered `pf_cnt`.
- **Reset**, asserted asynchronously at any time, including mid-handshake or with reads in flight:
  - Clears lock, `starve`, FIFO pointers, `cnt`, `pf_cnt` and `rsp_err`.
  - With requester valids low, every output reads 0: ready signals, `l1_valid`, rsp_valid signals, `p_busy`, `rsp_err`.
  - Responses for reads in flight before reset are the L1's responsibility; after reset they hit the empty-FIFO rule.
- Throughput is one accepted request per cycle and one response per cycle, concurrently.

## Test plan
- **Priority:** `d_valid=p_valid=1` (reads), `l1_ready=1`, STARVE_LIMIT=8 → 8 demand accepts (`starve` reaches 8), 9th cycle grants prefetch, `starve` returns to 0.
- **Lock:** prefetch granted with `l1_ready=0` for 3 cycles, `d_valid` rises in cycle 2 → `l1_addr` stays the prefetch address; `p_ready` asserts in the cycle `l1_ready=1`; demand is granted the next cycle.
- **Routing:** accept reads D, P, D, then 3 responses `0xA`, `0xB`, `0xC` → `d_rsp` gets `0xA` and `0xC`, `p_rsp` gets `0xB`; `p_busy` falls after `0xB` when `p_valid=0`.
- **Full:** MAX_OUTSTANDING=4, 4 reads accepted → 5th read gets ready=0 and `l1_valid=0`; a write is still accepted; the cycle after one response, the read is accepted.
- **Error/reset:** response with FIFO empty → no rsp_valid, `rsp_err=1` sticky. Assert `rst` mid-lock with 2 reads in flight → all state cleared; `l1_valid=0` while valids are low.
